// File: rtl/argmin_serial_ctrl_pkg.sv
// Shared census argmin definitions: state encoding, default cost width and a
// ceil(log2) helper used to size the disparity index.
package argmin_serial_ctrl_pkg;

  localparam int unsigned COST_WIDTH = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  // ceil(log2(n)); returns 0 for n <= 1
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/argmin_serial_ctrl_update.sv
// Combinational compare/select slice for the serial argmin.
// Ports:
//   first     - beat is idx 0 of a pixel; it seeds the running minimum
//   in_cost   - incoming cost
//   in_idx    - disparity index of the incoming cost
//   best_cost - running minimum so far
//   best_idx  - index of the running minimum
//   nxt_cost  - updated minimum
//   nxt_idx   - updated index
module argmin_update #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  first,
  input  logic [WIDTH-1:0]      in_cost,
  input  logic [ADDR_WIDTH-1:0] in_idx,
  input  logic [WIDTH-1:0]      best_cost,
  input  logic [ADDR_WIDTH-1:0] best_idx,
  output logic [WIDTH-1:0]      nxt_cost,
  output logic [ADDR_WIDTH-1:0] nxt_idx
);

  // Strict less-than: on a tie the earlier (lower) index is kept.
  always_comb begin
    nxt_cost = best_cost;
    nxt_idx  = best_idx;
    if (first || (in_cost < best_cost)) begin
      nxt_cost = in_cost;
      nxt_idx  = in_idx;
    end
  end

endmodule

// File: rtl/argmin_serial_ctrl.sv
// Sequential argmin engine: consumes NUM_DISP cost beats per pixel and
// reports the minimum cost and its disparity index.
// Ports:
//   clk, rst            - clock (rising edge), async active-high reset
//   en                  - global enable; 0 freezes all state
//   flush               - synchronous abort of the current pixel
//   in_valid/in_ready   - cost beat handshake; in_cost, in_last payload
//   out_valid/out_ready - result handshake; out_cost, out_disp payload
//   err_len             - sticky in_last vs. beat-count mismatch
module argmin_serial_ctrl
  import argmin_serial_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = COST_WIDTH,
  parameter int unsigned NUM_DISP   = 64,
  parameter int unsigned ADDR_WIDTH = clog2(NUM_DISP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_cost,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_cost,
  output logic [ADDR_WIDTH-1:0] out_disp,
  output logic                  err_len
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_DISP - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [WIDTH-1:0]      best_cost;
  logic [ADDR_WIDTH-1:0] best_idx;
  logic [WIDTH-1:0]      nxt_cost;
  logic [ADDR_WIDTH-1:0] nxt_idx;
  logic                  accept;
  logic                  xfer;
  logic                  at_last;

  // In DONE a beat is only taken when the result leaves the same cycle.
  assign in_ready = ~rst & en & ~flush & ((state == ST_ACCUM) | out_ready);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready & en & ~flush;
  assign at_last  = (idx == LAST_IDX);

  argmin_update #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_update (
    .first     (idx == '0),
    .in_cost   (in_cost),
    .in_idx    (idx),
    .best_cost (best_cost),
    .best_idx  (best_idx),
    .nxt_cost  (nxt_cost),
    .nxt_idx   (nxt_idx)
  );

  // Controller state, running minimum and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACCUM;
      idx       <= '0;
      best_cost <= '0;
      best_idx  <= '0;
      out_valid <= 1'b0;
      out_cost  <= '0;
      out_disp  <= '0;
      err_len   <= 1'b0;
    end else if (en) begin
      if (flush) begin
        state     <= ST_ACCUM;
        idx       <= '0;
        out_valid <= 1'b0;
        err_len   <= 1'b0;
      end else begin
        if (xfer) begin
          state     <= ST_ACCUM;
          out_valid <= 1'b0;
        end
        if (accept) begin
          best_cost <= nxt_cost;
          best_idx  <= nxt_idx;
          if (in_last != at_last) err_len <= 1'b1;
          if (at_last) begin
            out_cost  <= nxt_cost;
            out_disp  <= nxt_idx;
            out_valid <= 1'b1;
            state     <= ST_DONE;
            idx       <= '0;
          end else begin
            idx <= idx + ADDR_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_argmin_serial_ctrl.sv
module tb_argmin_serial_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned ND = 4;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst, en, flush, in_valid, in_ready, in_last;
  logic [W-1:0]  in_cost;
  logic          out_valid, out_ready, err_len;
  logic [W-1:0]  out_cost;
  logic [AW-1:0] out_disp;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int cost;
    int disp;
  } exp_t;
  exp_t exp_q[$];

  argmin_serial_ctrl #(.WIDTH(W), .NUM_DISP(ND), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cost   (in_cost),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cost  (out_cost),
    .out_disp  (out_disp),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every result transfer against the scoreboard.
  always @(negedge clk) begin
    if (!rst && en && !flush && out_valid && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_cost", int'(out_cost), e.cost);
        chk("out_disp", int'(out_disp), e.disp);
      end
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic beat(input int cost, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_cost  = W'(cost);
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pixel(input int c0, input int c1, input int c2, input int c3,
                       input int ecost, input int edisp);
    exp_t e;
    e.cost = ecost;
    e.disp = edisp;
    exp_q.push_back(e);
    beat(c0, 1'b0);
    beat(c1, 1'b0);
    beat(c2, 1'b0);
    beat(c3, 1'b1);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_cost = '0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_cost", int'(out_cost), 0);
    chk("rst_err_len", int'(err_len), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: basic pixel and latency
    e.cost = 5; e.disp = 1; exp_q.push_back(e);
    beat(9, 1'b0); beat(5, 1'b0); beat(7, 1'b0);
    chk("lat_before_last", int'(out_valid), 0);
    beat(6, 1'b1);
    chk("lat_after_last", int'(out_valid), 1);

    // 2: ties and all-max
    pixel(3, 3, 3, 3, 3, 0);
    pixel(8, 2, 9, 2, 2, 1);
    pixel(255, 255, 255, 255, 255, 0);

    // 3: backpressure with next beat waiting
    @(posedge clk); #1;
    out_ready = 1'b0;
    pixel(6, 4, 5, 7, 4, 1);
    in_valid = 1'b1; in_cost = W'(4); in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_cost", int'(out_cost), 4);
      chk("bp_out_disp", int'(out_disp), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    e.cost = 0; e.disp = 3; exp_q.push_back(e);
    @(negedge clk);
    chk("handoff_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    beat(1, 1'b0); beat(1, 1'b0); beat(0, 1'b1);

    // 4: early in_last
    e.cost = 2; e.disp = 2; exp_q.push_back(e);
    beat(5, 1'b0); beat(6, 1'b0);
    chk("err_before", int'(err_len), 0);
    beat(2, 1'b1);
    chk("err_set", int'(err_len), 1);
    beat(8, 1'b1);
    chk("err_result_valid", int'(out_valid), 1);
    repeat (3) @(posedge clk);
    #1 chk("err_sticky", int'(err_len), 1);

    // 5: flush mid-pixel, then async reset mid-pixel
    beat(10, 1'b0); beat(1, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_cost = W'(0);
    @(negedge clk);
    chk("flush_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_err_clr", int'(err_len), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    pixel(7, 8, 6, 9, 6, 2);
    beat(3, 1'b0); beat(2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_cost", int'(out_cost), 0);
    chk("arst_out_disp", int'(out_disp), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    pixel(9, 9, 1, 2, 1, 2);

    // 6: enable stall mid-pixel
    e.cost = 2; e.disp = 2; exp_q.push_back(e);
    beat(4, 1'b0); beat(3, 1'b0);
    en = 1'b0; in_valid = 1'b1; in_cost = W'(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1 en = 1'b1;
    beat(2, 1'b0); beat(5, 1'b1);

    repeat (4) @(posedge clk);
    #1 chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/argmin_serial_ctrl.md
Name: argmin_serial_ctrl

Overview:
Sequential argmin engine for the stereo census matcher. It accepts a stream of per-disparity matching costs for one pixel, NUM_DISP beats per pixel, and reports the minimum cost and its disparity index. It gives a low-area alternative to the pipelined argmin tree when one compare/select slice is time-shared across all disparities. It sits between the Hamming-cost generator and the disparity output FIFO, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, cost bit width.
NUM_DISP, 64, candidates per pixel; must be ≥2.
ADDR_WIDTH, 6, disparity index width; must equal ceil(log2(NUM_DISP)).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
en  in  1  global enable; 0 freezes all state.
flush  in  1  synchronous abort of the current pixel.
in_valid  in  1  cost beat valid.
in_ready  out  1  controller accepts a beat this cycle.
in_cost  in  WIDTH  cost for the current disparity index.
in_last  in  1  upstream marks the final beat of a pixel (checked, not trusted).
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_cost  out  WIDTH  minimum cost.
out_disp  out  ADDR_WIDTH  index of the minimum cost.
err_len  out  1  sticky in_last/count mismatch flag.

Behaviour:
- Beat accept = in_valid & in_ready. Result transfer = out_valid & out_ready & en.
- Reset state is ACCUM with idx=0. On reset: out_valid=0, out_cost=0, out_disp=0, err_len=0, best regs=0. in_ready is 0 while rst is high.
- FSM has two states, ACCUM and DONE:
  - ACCUM: in_ready=en. out_valid=0.
  - DONE: out_valid=1. in_ready=en & out_ready, so a zero-bubble handoff is possible.
- Accept at idx=0: best_cost<=in_cost, best_idx<=0.
- Accept at idx>0: update only if in_cost < best_cost (strict). Ties keep the lower index, matching tree semantics (left wins on ≤).
- idx increments on every accept.
- Accept at idx=NUM_DISP-1:
  - out_cost/out_disp are loaded with the final min/index, including the final beat's comparison.
  - State goes to DONE; idx goes to 0.
  - Latency: out_valid rises 1 cycle after the last accepted beat.
- DONE with transfer and no accept: go to ACCUM.
- DONE with transfer and accept in the same cycle: the beat is treated as idx=0 of the next pixel, and state goes to ACCUM.
- out_cost/out_disp hold stable while out_valid=1 and no transfer occurs.
- The counter is authoritative. on an accepted beat, in_last=1 with idx≠NUM_DISP-1, or in_last=0 with idx=NUM_DISP-1, sets err_len. err_len stays set until flush or reset; processing is unaffected.
- flush (sampled when en=1) has the highest priority:
  - state goes to ACCUM, idx=0, out_valid=0, err_len=0.
  - Any beat presented that cycle is not accepted; in_ready=0 during flush.
- en=0: no register changes, in_ready=0, no transfer. out_valid keeps its current value.
- Asynchronous reset mid-pixel discards partial results; the next accepted beat is idx=0.
- Width rules: no arithmetic on costs, only an unsigned compare. idx wraps from NUM_DISP-1 to 0 explicitly, not by overflow.

Decomposition:
- Shared census package holds:
  - the state encoding (ST_ACCUM=1'b0, ST_DONE=1'b1);
  - a clog2 function to derive ADDR_WIDTH;
  - COST_WIDTH default shared with the cost generator.
- One natural sub-module, argmin_update: combinational strict-less compare plus best/idx select, taking the first-beat flag. Registers use the existing dff module with en.

Test Plan (WIDTH=8, NUM_DISP=4):
1. Costs 9,5,7,6 back-to-back, out_ready=1 -> out_cost=5, out_disp=1; out_valid high exactly 1 cycle after the 4th accept.
2. Ties: 3,3,3,3 -> disp=0. Then 8,2,9,2 -> disp=1. Then 255,255,255,255 -> cost=255, disp=0.
3. Backpressure: result pending with out_ready=0 for 5 cycles while the next pixel's beat is valid -> in_ready=0 and out_* stable. When out_ready=1, the transfer and the beat accept occur in the same cycle; the next pixel 4,1,1,0 gives cost 0, disp 3.
4. in_last asserted on beat idx 2 -> err_len=1 from the next cycle. The result still appears after 4 beats, and err_len stays 1 until flush.
5. flush after 2 accepted beats (10,1), then 7,8,6,9 -> cost=6, disp=2, err_len=0. Async rst mid-pixel -> all outputs 0 immediately, next result correct.
6. en=0 for 3 cycles mid-pixel, with in_valid=1 -> in_ready=0 and state frozen. On resume the result is identical to the unstalled run.
